combo_lock: RTL and testbench
=============================

COMBO_LOCK -- requirements
Module: combo_lock

Interface
REQ-001 Parameter CODE, default 8'b00_01_10_11: expected key sequence, 4 digits of 2 bits, first digit in bits [7:6].
REQ-002 Parameter MAX_TRIES, default 3: consecutive failed entries that trigger lockout, range 1..7.
REQ-003 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clock cycles, range 1..65535.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000: inactivity limit in cycles, range 2..65535, used only with the timeout feature.
REQ-005 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 KEY_P  input  4  one-cycle key pulses from the upstream rising-edge detectors; bit i = key i.
REQ-008 RELOCK_P  input  1  one-cycle pulse that relocks from OPEN.
REQ-009 UNLOCK  output  1  registered; high while the state is OPEN.
REQ-010 ERR  output  1  registered; one-cycle pulse on each failed 4-digit entry.
REQ-011 LOCKOUT  output  1  registered; high while the state is LOCKED.
REQ-012 DIGIT_CNT  output  2  registered; number of digits accepted in the current entry.

Function
REQ-013 The states SHALL be IDLE, ENTRY, OPEN and LOCKED.
REQ-014 A key event SHALL be any cycle with KEY_P != 0; exactly one bit set yields digit = index of that bit.
REQ-015 A key event with more than one bit set SHALL count as a digit and SHALL be marked a mismatch.
REQ-016 In IDLE, a key event SHALL go to ENTRY with DIGIT_CNT=1 and the mismatch flag loaded from comparison of the digit with CODE[7:6].
REQ-017 In ENTRY, each key event SHALL compare the digit with CODE digit DIGIT_CNT, OR the result into the mismatch flag, and increment DIGIT_CNT.
REQ-018 On the 4th digit with no mismatch: the block SHALL go to OPEN, set UNLOCK the next cycle (1-cycle latency from the sampled pulse), clear the fail counter, and set DIGIT_CNT=0.
REQ-019 On the 4th digit with any mismatch: the block SHALL pulse ERR for 1 cycle, increment the fail counter, set DIGIT_CNT=0, and go to IDLE.
REQ-020 A failure that makes the fail counter equal MAX_TRIES SHALL go to LOCKED instead of IDLE, load the lockout counter with LOCKOUT_CYCLES, and still pulse ERR.
REQ-021 In LOCKED: KEY_P SHALL be ignored, the counter SHALL decrement each cycle, and at 0 the block SHALL go to IDLE with the fail counter cleared; LOCKOUT is high for exactly LOCKOUT_CYCLES cycles.
REQ-022 In OPEN: KEY_P SHALL be ignored; RELOCK_P SHALL go to IDLE and deassert UNLOCK the next cycle.
REQ-023 RELOCK_P outside OPEN SHALL have no effect.
REQ-024 A 5th key pulse arriving in the same cycle the 4th is evaluated cannot occur, because pulses are one per cycle; a key in the cycle after OPEN is entered SHALL be ignored.

Reset
REQ-025 RST_N low SHALL asynchronously force IDLE and UNLOCK=0, ERR=0, LOCKOUT=0, DIGIT_CNT=0, and clear the fail, lockout and timeout counters.
REQ-026 Reset mid-entry or mid-lockout SHALL abandon all progress; there is no retained state.

Configuration
REQ-027 With COMBO_LOCK_TIMEOUT_EN defined: in ENTRY, TIMEOUT_CYCLES consecutive cycles without a key event SHALL return to IDLE with DIGIT_CNT=0, no ERR, and no fail-count change; each key event restarts the count.
REQ-028 Without COMBO_LOCK_TIMEOUT_EN: ENTRY SHALL wait indefinitely, and no timeout counter SHALL exist in the netlist.

Structure
REQ-029 A shared package combo_lock_pkg SHALL hold the state enum (IDLE, ENTRY, OPEN, LOCKED), the digit width constant (2), and the digit count constant (4).
REQ-030 A sub-module combo_lock_timer (loadable down-counter with a zero flag) SHALL serve the lockout and, when enabled, the timeout counting; the FSM stays in combo_lock.

Verification
REQ-031 Reset, then keys 0,1,2,3 (KEY_P=0001,0010,0100,1000), spaced 3 cycles apart -> UNLOCK=1 one cycle after the 4th pulse; ERR never asserts.
REQ-032 Keys 0,1,3,3 -> ERR high for exactly 1 cycle after the 4th pulse, UNLOCK stays 0, DIGIT_CNT returns to 0.
REQ-033 Three wrong entries with MAX_TRIES=3 and LOCKOUT_CYCLES=16 -> LOCKOUT high for 16 cycles; the correct code during LOCKOUT does not unlock; the correct code after LOCKOUT unlocks.
REQ-034 KEY_P=0011 as the first digit followed by 1,2,3 -> ERR.
REQ-035 OPEN plus RELOCK_P -> UNLOCK=0 next cycle; RELOCK_P in IDLE -> no change.
REQ-036 RST_N low after 2 digits, or mid-LOCKOUT -> outputs 0 immediately without a clock edge; with COMBO_LOCK_TIMEOUT_EN and TIMEOUT_CYCLES=10, 2 digits then idle for 10 cycles -> DIGIT_CNT=0 and no ERR.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// -----------------------------------------------------------------------------
// combo_lock_pkg
// Shared types and constants for the combination lock:
//   state_t      FSM states IDLE / ENTRY / OPEN / LOCKED
//   DIGIT_W      bits per code digit (2)
//   DIGIT_COUNT  digits per entry (4)
//   decode_key   one-hot key pulse vector -> digit + "more than one key" flag
//   code_digit   selects digit n of the packed code, first digit in the MSBs
// -----------------------------------------------------------------------------
package combo_lock_pkg;

    localparam int DIGIT_W     = 2;
    localparam int DIGIT_COUNT = 4;
    localparam int NUM_KEYS    = 1 << DIGIT_W;
    localparam int CODE_W      = DIGIT_W * DIGIT_COUNT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        OPEN   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t digit;
        logic   multi;   // more than one key in the same cycle
    } key_t;

    function automatic key_t decode_key(input logic [NUM_KEYS-1:0] key_p);
        key_t k;
        k.digit = '0;
        // x & (x-1) clears the lowest set bit; anything left means >1 key
        k.multi = (key_p & (key_p - NUM_KEYS'(1))) != '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_p[i]) k.digit = digit_t'(i);
        end
        return k;
    endfunction

    function automatic digit_t code_digit(input logic [CODE_W-1:0] code,
                                          input digit_t             idx);
        digit_t d;
        case (idx)
            2'd0:    d = code[7:6];
            2'd1:    d = code[5:4];
            2'd2:    d = code[3:2];
            default: d = code[1:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/combo_lock_if.sv
// -----------------------------------------------------------------------------
// combo_lock_if
// Key/relock inputs and status outputs of the combination lock.
//   key_p     [3:0]  one-cycle key pulses, bit i = key i
//   relock_p         one-cycle pulse, relocks from OPEN
//   unlock           high while OPEN
//   err              one-cycle pulse per failed entry
//   lockout          high while LOCKED
//   digit_cnt [1:0]  digits accepted in the current entry
// Modports: master drives the pulses (keypad side), slave is the lock.
// -----------------------------------------------------------------------------
interface combo_lock_if;
    import combo_lock_pkg::*;

    logic [NUM_KEYS-1:0] key_p;
    logic                relock_p;
    logic                unlock;
    logic                err;
    logic                lockout;
    digit_t              digit_cnt;

    modport master (
        output key_p, relock_p,
        input  unlock, err, lockout, digit_cnt
    );

    modport slave (
        input  key_p, relock_p,
        output unlock, err, lockout, digit_cnt
    );

endinterface

// File: rtl/combo_lock_timer.sv
// -----------------------------------------------------------------------------
// combo_lock_timer
// Loadable down-counter with a zero flag. Counting stops at zero.
//   clk, rst_n  clock, async active-low reset (clears the count)
//   load        load load_val this cycle (wins over en)
//   load_val    value to load
//   en          decrement when nonzero
//   zero        count == 0
// -----------------------------------------------------------------------------
module combo_lock_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/combo_lock.sv
// -----------------------------------------------------------------------------
// combo_lock
// Four-digit combination lock with fail counting and timed lockout.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    combo_lock_if.slave: key_p, relock_p in; unlock, err, lockout,
//          digit_cnt out (all outputs registered)
// Parameters: CODE (first digit in [7:6]), MAX_TRIES, LOCKOUT_CYCLES,
//             TIMEOUT_CYCLES.
// Optional feature: define COMBO_LOCK_TIMEOUT_EN to abandon an entry after
// TIMEOUT_CYCLES cycles without a key; otherwise ENTRY waits indefinitely and
// no timeout counter is built.
// -----------------------------------------------------------------------------
module combo_lock
    import combo_lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE           = 8'b00_01_10_11,
    parameter int                MAX_TRIES      = 3,
    parameter int                LOCKOUT_CYCLES = 16,
    parameter int                TIMEOUT_CYCLES = 1000
) (
    input logic          clk,
    input logic          rst_n,
    combo_lock_if.slave  bus
);

    // Timers are loaded with N-1 and the exit fires when they read zero, so
    // the state they guard lasts exactly N cycles.
    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  MAX_FAILS = 3'(MAX_TRIES);

    state_t     state;
    logic [2:0] fail_cnt;
    logic       mismatch;
    digit_t     digit_cnt;
    logic       unlock;
    logic       err;
    logic       lockout;

    key_t       key;
    logic       key_evt;
    logic       digit_bad;
    logic       entry_bad;
    logic       last_digit;
    logic       lock_load;
    logic       lock_zero;
    logic       timeout;

    // NOTE: every signal assigned here gets a value on every path, so the
    // block stays purely combinational and no latch is inferred.
    always_comb begin
        key        = decode_key(bus.key_p);
        key_evt    = (bus.key_p != '0);
        // digit_cnt is 0 in IDLE, so the same compare covers the first digit
        digit_bad  = key.multi || (key.digit != code_digit(CODE, digit_cnt));
        entry_bad  = mismatch || digit_bad;
        last_digit = (digit_cnt == digit_t'(DIGIT_COUNT - 1));
        lock_load  = (state == ENTRY) && key_evt && last_digit && entry_bad &&
                     (fail_cnt + 3'd1 == MAX_FAILS);
    end

    combo_lock_timer #(.WIDTH(16)) u_lockout_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (LOCK_LOAD),
        .en       (state == LOCKED),
        .zero     (lock_zero)
    );

`ifdef COMBO_LOCK_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic timeout_zero;

    // Every key that starts or continues an entry restarts the idle window.
    combo_lock_timer #(.WIDTH(16)) u_timeout_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == IDLE || state == ENTRY) && key_evt),
        .load_val (TIMEOUT_LOAD),
        .en       ((state == ENTRY) && !key_evt),
        .zero     (timeout_zero)
    );

    assign timeout = (state == ENTRY) && !key_evt && timeout_zero;
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state and outputs update with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fail_cnt  <= '0;
            mismatch  <= 1'b0;
            digit_cnt <= '0;
            unlock    <= 1'b0;
            err       <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_evt) begin
                        state     <= ENTRY;
                        digit_cnt <= digit_t'(1);
                        mismatch  <= digit_bad;
                    end
                end

                ENTRY: begin
                    if (key_evt) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                            if (!entry_bad) begin
                                state    <= OPEN;
                                unlock   <= 1'b1;
                                fail_cnt <= '0;
                            end else begin
                                err      <= 1'b1;
                                fail_cnt <= fail_cnt + 3'd1;
                                if (lock_load) begin
                                    state   <= LOCKED;
                                    lockout <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            digit_cnt <= digit_cnt + digit_t'(1);
                            mismatch  <= entry_bad;
                        end
                    end else if (timeout) begin
                        state     <= IDLE;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                    end
                end

                OPEN: begin
                    if (bus.relock_p) begin
                        state  <= IDLE;
                        unlock <= 1'b0;
                    end
                end

                LOCKED: begin
                    if (lock_zero) begin
                        state    <= IDLE;
                        lockout  <= 1'b0;
                        fail_cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unlock    = unlock;
    assign bus.err       = err;
    assign bus.lockout   = lockout;
    assign bus.digit_cnt = digit_cnt;

endmodule

// File: tb/tb_combo_lock.sv
// -----------------------------------------------------------------------------
// tb_combo_lock
// Directed bench for combo_lock (CODE = keys 0,1,2,3, MAX_TRIES = 3,
// LOCKOUT_CYCLES = 16, TIMEOUT_CYCLES = 10). Inputs change on the falling
// edge; outputs are read on the falling edge, half a cycle after the rising
// edge that produced them.
// -----------------------------------------------------------------------------
module tb_combo_lock;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    combo_lock_if bus ();

    combo_lock #(
        .CODE           (8'b00_01_10_11),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec   = 0;
    int n_miss  = 0;
    int err_cnt = 0;
    int lo_cnt  = 0;

    // Running counts of err pulses and lockout-high cycles.
    always @(negedge clk) begin
        if (bus.err)     err_cnt++;
        if (bus.lockout) lo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_p = k;
        @(negedge clk);
        bus.key_p = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four key pulses spaced 3 cycles apart; returns half a cycle after the
    // edge that sampled the last one.
    task automatic enter(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        press(a); idle(1);
        press(b); idle(1);
        press(c); idle(1);
        press(d);
    endtask

    task automatic relock();
        @(negedge clk);
        bus.relock_p = 1'b1;
        @(negedge clk);
        bus.relock_p = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.key_p    = '0;
        bus.relock_p = 1'b0;
        rst_n        = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_unlock",  bus.unlock,    0);
        check("rst_err",     bus.err,       0);
        check("rst_lockout", bus.lockout,   0);
        check("rst_dcnt",    bus.digit_cnt, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Correct code, digit count tracked per key.
        press(4'b0001); check("ok_dcnt1", bus.digit_cnt, 1); idle(1);
        press(4'b0010); check("ok_dcnt2", bus.digit_cnt, 2); idle(1);
        press(4'b0100); check("ok_dcnt3", bus.digit_cnt, 3); idle(1);
        press(4'b1000);
        check("ok_unlock", bus.unlock,    1);
        check("ok_dcnt0",  bus.digit_cnt, 0);
        check("ok_no_err", err_cnt,       0);

        // Keys are ignored while OPEN.
        press(4'b0001);
        check("open_key_unlock", bus.unlock,    1);
        check("open_key_dcnt",   bus.digit_cnt, 0);

        // Relock from OPEN, then relock in IDLE and mid-entry.
        relock();
        check("relock_unlock", bus.unlock, 0);
        relock();
        check("relock_idle_unlock", bus.unlock,    0);
        check("relock_idle_dcnt",   bus.digit_cnt, 0);
        press(4'b0001);
        relock();
        check("relock_entry_dcnt", bus.digit_cnt, 1);
        press(4'b0010); idle(1);
        press(4'b0100); idle(1);
        press(4'b1000);
        check("relock_entry_unlock", bus.unlock, 1);
        relock();

        // Wrong last digit: keys 0,1,3,3.
        enter(4'b0001, 4'b0010, 4'b1000, 4'b1000);
        check("bad_err",    bus.err,       1);
        check("bad_unlock", bus.unlock,    0);
        check("bad_dcnt",   bus.digit_cnt, 0);
        idle(1);
        check("bad_err_1cyc", bus.err, 0);
        check("bad_err_cnt",  err_cnt, 1);

        // Two keys at once count as a (wrong) digit.
        press(4'b0011);
        check("multi_dcnt", bus.digit_cnt, 1);
        idle(1);
        press(4'b0010); idle(1);
        press(4'b0100); idle(1);
        press(4'b1000);
        check("multi_err",    bus.err,    1);
        check("multi_unlock", bus.unlock, 0);

        // Third failure locks out for 16 cycles.
        lo_cnt = 0;
        enter(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        check("lock_err",     bus.err,     1);
        check("lock_lockout", bus.lockout, 1);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("lock_code_unlock", bus.unlock,    0);
        check("lock_code_dcnt",   bus.digit_cnt, 0);
        check("lock_still",       bus.lockout,   1);
        guard = 0;
        while (bus.lockout && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("lock_released", bus.lockout, 0);
        check("lock_len",      lo_cnt,      16);
        check("lock_err_cnt",  err_cnt,     3);

        // Fail counter was cleared on leaving LOCKED.
        idle(1);
        enter(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        check("post_lock_err",     bus.err,     1);
        check("post_lock_lockout", bus.lockout, 0);
        idle(1);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("post_lock_unlock", bus.unlock, 1);
        relock();

        // Inactivity in ENTRY.
        press(4'b0001); idle(1);
        press(4'b0010);
        check("idle_dcnt2", bus.digit_cnt, 2);
`ifdef COMBO_LOCK_TIMEOUT_EN
        idle(9);
        check("to_before", bus.digit_cnt, 2);
        idle(1);
        check("to_dcnt0",  bus.digit_cnt, 0);
        check("to_no_err", err_cnt,       4);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("to_unlock", bus.unlock, 1);
`else
        idle(30);
        check("wait_dcnt", bus.digit_cnt, 2);
        press(4'b0100); idle(1);
        press(4'b1000);
        check("wait_unlock", bus.unlock, 1);
`endif
        relock();

        // Reset in the middle of an entry.
        press(4'b0001); idle(1);
        press(4'b0010);
        check("rst_mid_pre", bus.digit_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_dcnt", bus.digit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a lockout.
        enter(4'b1000, 4'b1000, 4'b1000, 4'b1000); idle(1);
        enter(4'b1000, 4'b1000, 4'b1000, 4'b1000); idle(1);
        enter(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        check("rst_lock_pre", bus.lockout, 1);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_lock_lockout", bus.lockout, 0);
        check("rst_lock_unlock",  bus.unlock,  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        check("rst_lock_unlock_after", bus.unlock, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
